// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target and controller state encodings, bus ACK levels,
// and the default target address.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWriteByte,
    StWriteAck,
    StReadByte,
    StReadAck,
    StWaitStop
  } slv_state_e;

  typedef enum logic [3:0] {
    MstIdle,
    MstStart,
    MstAddr,
    MstAddrAck,
    MstWrite,
    MstWriteAck,
    MstRead,
    MstReadAck,
    MstStop
  } mst_state_e;

  localparam logic Ack  = 1'b0;
  localparam logic Nack = 1'b1;

  localparam logic [6:0] DefaultSlaveAddr = 7'h50;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchronizers with SCL edge and START/STOP condition detection.
// All flops preset to 1 so reset looks like an idle bus.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_p,
  output logic stop_p
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = ~scl_prev_q & scl_s;
  assign scl_fall = scl_prev_q & ~scl_s;
  // SDA edges while SCL is high are bus conditions, never data.
  assign start_p  = scl_s & sda_prev_q & ~sda_s;
  assign stop_p   = scl_s & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with 7-bit addressing: ACKs its own address, delivers written bytes
// and serves read bytes from user logic. Never stretches SCL.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = DefaultSlaveAddr,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rd_mode,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert asynchronously, release synchronously to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic scl_rise, scl_fall, sda_s, start_p, stop_p;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl),
    .sda     (sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .sda_s   (sda_s),
    .start_p (start_p),
    .stop_p  (stop_p)
  );

  slv_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shifter_q, shifter_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rd_mode_q, rd_mode_d;
  logic       busy_q, busy_d;
  logic       byte_done_q, byte_done_d;
  logic       rx_valid_q, rx_valid_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       tx_load;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shifter_d   = shifter_q;
    rx_data_d   = rx_data_q;
    sda_oe_d    = sda_oe_q;
    rd_mode_d   = rd_mode_q;
    busy_d      = busy_q;
    byte_done_d = byte_done_q;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    tx_load     = 1'b0;

    if (start_p) begin
      state_d     = StAddr;
      bit_cnt_d   = 3'd7;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      byte_done_d = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_p) begin
      state_d     = StIdle;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      byte_done_d = 1'b0;
      stop_det_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: sda_oe_d = 1'b0;

        StAddr: begin
          if (scl_rise) begin
            shifter_d = {shifter_q[6:0], sda_s};
            if (bit_cnt_q == 3'd0) begin
              // shifter_q[6:0] already holds the address; sda_s is the R/W bit.
              if (shifter_q[6:0] == SLAVE_ADDR) begin
                rd_mode_d   = sda_s;
                busy_d      = 1'b1;
                byte_done_d = 1'b1;
              end else begin
                state_d = StWaitStop;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            state_d     = StAddrAck;
            sda_oe_d    = 1'b1;
            if (rd_mode_q) begin
              tx_load   = 1'b1;
              shifter_d = tx_data;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd7;
            if (rd_mode_q) begin
              sda_oe_d = ~shifter_q[7];
              state_d  = StReadByte;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWriteByte;
            end
          end
        end

        StWriteByte: begin
          if (scl_rise) begin
            shifter_d = {shifter_q[6:0], sda_s};
            if (bit_cnt_q == 3'd0) begin
              rx_data_d   = {shifter_q[6:0], sda_s};
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            state_d     = StWriteAck;
            sda_oe_d    = 1'b1;
          end
        end

        StWriteAck: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = StWriteByte;
          end
        end

        StReadByte: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = StReadAck;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              sda_oe_d  = ~shifter_q[bit_cnt_d];
            end
          end
        end

        StReadAck: begin
          if (scl_rise) begin
            if (sda_s == Ack) begin
              tx_load     = 1'b1;
              shifter_d   = tx_data;
              byte_done_d = 1'b1;
            end else begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oe_d    = ~shifter_q[7];
            bit_cnt_d   = 3'd7;
            state_d     = StReadByte;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd7;
      shifter_q   <= 8'h00;
      rx_data_q   <= 8'h00;
      sda_oe_q    <= 1'b0;
      rd_mode_q   <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shifter_q   <= shifter_d;
      rx_data_q   <= rx_data_d;
      sda_oe_q    <= sda_oe_d;
      rd_mode_q   <= rd_mode_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      rx_valid_q  <= rx_valid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_req    = tx_load;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rd_mode   = rd_mode_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level bench for i2c_slave: a behavioural controller drives SCL/SDA, a monitor
// scoreboards written bytes and counts pulses.
module tb_i2c_slave;

  localparam time Q = 100ns;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req, rx_valid, rd_mode, busy, start_det, stop_det;
  logic [7:0] rx_data;
  wire        sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5ns clk = ~clk;

  i2c_slave #(
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_mode  (rd_mode),
    .busy     (busy),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  int total = 0;
  int bad = 0;
  int n_rxv = 0, n_txreq = 0, n_start = 0, n_stop = 0, n_slave_low = 0;
  int s_rxv, s_txreq, s_start, s_stop, s_slave_low;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling clk edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      check("rx_expected", 32'(exp_rx.size() > 0), 32'd1);
      if (exp_rx.size() > 0) check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
    end
    if (tx_req) n_txreq++;
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (reset_n && !m_oe && sda === 1'b0) n_slave_low++;
  end

  task automatic snap();
    s_rxv = n_rxv; s_txreq = n_txreq; s_start = n_start; s_stop = n_stop;
    s_slave_low = n_slave_low;
  endtask

  task automatic put_bit(input logic b);
    m_oe = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_oe = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_start();
    m_oe = 1'b0; #Q; scl = 1'b1; #Q; m_oe = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; #Q; scl = 1'b1; #Q; m_oe = 1'b0; #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    for (int i = 7; i >= 0; i--) get_bit(d[i]);
    put_bit(mack);
  endtask

  logic       ack;
  logic [7:0] rd;

  initial begin
    #95ns;
    check("reset_outputs", {22'd0, busy, rd_mode, rx_data, rx_valid, tx_req, start_det, stop_det},
          32'd0);
    reset_n = 1'b1;
    #(4*Q);

    // Write 0xA5
    snap();
    exp_rx.push_back(8'hA5);
    bus_start();
    write_byte(8'hA0, ack); check("wr_addr_ack", 32'(ack), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_rd_mode", 32'(rd_mode), 32'd0);
    write_byte(8'hA5, ack); check("wr_data_ack", 32'(ack), 32'd0);
    bus_stop();
    check("wr_rx_pulses", 32'(n_rxv - s_rxv), 32'd1);
    check("wr_start_pulses", 32'(n_start - s_start), 32'd1);
    check("wr_stop_pulses", 32'(n_stop - s_stop), 32'd1);
    check("wr_busy_after_stop", 32'(busy), 32'd0);

    // Address mismatch
    snap();
    bus_start();
    write_byte(8'hA2, ack); check("mm_addr_nack", 32'(ack), 32'd1);
    bus_stop();
    check("mm_slave_drove", 32'(n_slave_low - s_slave_low), 32'd0);
    check("mm_rx_pulses", 32'(n_rxv - s_rxv), 32'd0);
    check("mm_busy", 32'(busy), 32'd0);

    // Read 0x3C (ACK) then 0xC3 (NACK)
    snap();
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'hC3);
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'hA1, ack); check("rd_addr_ack", 32'(ack), 32'd0);
    check("rd_rd_mode", 32'(rd_mode), 32'd1);
    for (int i = 7; i >= 0; i--) get_bit(rd[i]);
    tx_data = 8'hC3;
    put_bit(1'b0);
    check("rd_byte0", {24'd0, rd}, {24'd0, exp_rd.pop_front()});
    read_byte(rd, 1'b1);
    check("rd_byte1", {24'd0, rd}, {24'd0, exp_rd.pop_front()});
    #Q;
    check("rd_sda_released", 32'(sda), 32'd1);
    check("rd_busy_after_nack", 32'(busy), 32'd0);
    check("rd_tx_req_pulses", 32'(n_txreq - s_txreq), 32'd2);
    bus_stop();

    // Repeated START: write 0x11 then read 0x7E
    snap();
    exp_rx.push_back(8'h11);
    bus_start();
    write_byte(8'hA0, ack); check("rs_wr_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h11, ack); check("rs_wr_data_ack", 32'(ack), 32'd0);
    check("rs_rd_mode_w", 32'(rd_mode), 32'd0);
    tx_data = 8'h7E;
    bus_start();
    write_byte(8'hA1, ack); check("rs_rd_addr_ack", 32'(ack), 32'd0);
    check("rs_rd_mode_r", 32'(rd_mode), 32'd1);
    read_byte(rd, 1'b1);
    check("rs_rd_byte", {24'd0, rd}, 32'h7E);
    bus_stop();
    check("rs_rx_data", {24'd0, rx_data}, 32'h11);
    check("rs_start_pulses", 32'(n_start - s_start), 32'd2);

    // Abort after 4 data bits, then a full write of 0x5A
    snap();
    bus_start();
    write_byte(8'hA0, ack); check("ab_addr_ack", 32'(ack), 32'd0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    bus_stop();
    check("ab_rx_pulses", 32'(n_rxv - s_rxv), 32'd0);
    check("ab_stop_pulses", 32'(n_stop - s_stop), 32'd1);
    check("ab_sda_released", 32'(sda), 32'd1);
    exp_rx.push_back(8'h5A);
    bus_start();
    write_byte(8'hA0, ack); check("ab2_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h5A, ack); check("ab2_data_ack", 32'(ack), 32'd0);
    bus_stop();
    check("ab2_rx_pulses", 32'(n_rxv - s_rxv), 32'd1);

    // Reset while the target drives a 0 data bit
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'hA1, ack); check("rst_addr_ack", 32'(ack), 32'd0);
    #Q;
    check("rst_bit7_driven", 32'(sda), 32'd0);
    reset_n = 1'b0;
    #1ns;
    check("rst_sda_async", 32'(sda), 32'd1);
    check("rst_outputs", {22'd0, busy, rd_mode, rx_data, rx_valid, tx_req, start_det, stop_det},
          32'd0);
    #50ns;
    reset_n = 1'b1;
    #Q;
    snap();
    exp_rx.push_back(8'hC7);
    bus_start();
    write_byte(8'hA0, ack); check("post_rst_addr_ack", 32'(ack), 32'd0);
    write_byte(8'hC7, ack); check("post_rst_data_ack", 32'(ack), 32'd0);
    bus_stop();
    check("post_rst_rx_pulses", 32'(n_rxv - s_rxv), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    #Q;
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
